hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised hazard unit for the 5-stage pipeline. Replaces the fixed bypass/stall/mult-control trio.
//  Tracks outstanding long-latency (mult/div) destinations in a scoreboard. Generates RAW/WAW/load-use stalls.
//  Selects forwarding over NFWD downstream stages and arbitrates the single regfile write port between the
//  ALU/load path and multdiv results. Sits beside decode; consumes FD/DX/XM/MW instruction fields.
// PARAMETERS
//  NREG     32  architectural registers; register 0 hardwired zero
//  AW       5   register index width (clog2(NREG))
//  NFWD     2   forwarding stages (index 0 = XM youngest, NFWD-1 = MW oldest)
//  MD_DEPTH 2   max outstanding multdiv ops (power of 2, >=1)
//  DW       32  datapath width
// PORTS
//  clock        in  1          master clock, rising edge
//  reset        in  1          asynchronous, active-low; clears all state
//  id_valid     in  1          decode-stage instruction valid
//  id_rs_a      in  AW         source A index;  id_use_a in 1: A is read
//  id_rs_b      in  AW         source B index;  id_use_b in 1: B is read
//  id_rd        in  AW         destination;     id_wr    in 1: writes rd
//  id_is_md     in  1          instruction is mult/div
//  ex_is_load   in  1          DX-stage instruction is load;  ex_rd in AW: its rd
//  fwd_wr       in  NFWD       stage k writes a register
//  fwd_rd       in  NFWD*AW    stage k destination, k*AW slices
//  alu_wb_valid in  1          MW stage is writing regfile this cycle
//  md_done      in  1          multdiv result valid (held until accepted)
//  md_result    in  DW         multdiv result
//  md_ready     out 1          = !buf_valid | md_commit; md_done&&md_ready = accept
//  md_issue     out 1          id_is_md accepted this cycle (start pulse to multdiv)
//  stall        out 1          freeze PC/FD, bubble into DX
//  fwd_sel_a    out clog2(NFWD+1) 0 = regfile, k+1 = stage k;  fwd_sel_b out same, for B
//  md_commit    out 1          regfile write port carries multdiv result this cycle
//  md_wb_rd     out AW;  md_wb_data out DW   commit destination / data
//  md_err       out 1          sticky: md_done with empty tag FIFO
// BEHAVIOUR
//  Reset (reset=0): pend[]=0, FIFO ptrs/count=0, buf_valid=0, md_err=0; all outputs 0 except md_ready=1.
//  Scoreboard pend[NREG]: set at edge on md_issue for id_rd!=0; cleared at edge after md_commit of that rd.
//  Tag FIFO (MD_DEPTH): pushes id_rd on md_issue; pops on md_done&&md_ready; ptrs wrap modulo MD_DEPTH.
//  stall = id_valid & (raw | waw | lu | mdfull | wbhold), all combinational from registered state:
//   raw:    used source !=0 with pend[src]=1 (pre-commit value; clear-same-cycle still stalls 1 cycle)
//   waw:    id_wr & id_rd!=0 & pend[id_rd]
//   lu:     ex_is_load & ex_rd!=0 & used source == ex_rd
//   mdfull: id_is_md & count==MD_DEPTH
//   wbhold: buf_valid & alu_wb_valid (drains ALU writebacks so the result commits)
//  md_issue = id_valid & id_is_md & !stall.
//  Forwarding: per source, lowest k with fwd_wr[k] & fwd_rd[k]==src & src!=0 -> sel=k+1; else 0.
//   Register 0 never forwards; youngest stage wins.
//  Result buffer (1 entry): on accept, capture {FIFO head rd, md_result}, buf_valid=1.
//   md_commit = buf_valid & !alu_wb_valid; ALU writeback always has priority.
//   Commit and accept same cycle: buffer reloads; buf_valid stays 1.
//  md_done with count==0: no pop/capture, md_err set until reset.
//  Reset mid-op: all pending tags/results discarded; multdiv must be reset concurrently.
//  No latency from id_* to stall/fwd_sel (combinational); scoreboard effects visible next cycle.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs perf_raw_cnt, perf_lu_cnt, perf_wb_cnt (32b, saturating).
//   Each counts cycles where stall is due to raw|waw, lu, mdfull|wbhold respectively; reset to 0.
//  Undefined: the ports still exist, tied to 0, no counter flops.
// STRUCTURE
//  Shared package hazard_pkg: fwd select encodings (FWD_RF=0), opcode constants (MUL/DIV ALU op, LW=8, SW=7).
//  One sub-module: md_tag_fifo (MD_DEPTH x AW, push/pop/count/empty/full).
//  Top holds scoreboard, stall logic, fwd priority encoders, result buffer, optional perf counters.
// TESTING
//  1 add r3 in XM, add r3 in MW, id reads r3 as A -> fwd_sel_a=1 (XM wins), stall=0.
//  2 ex_is_load ex_rd=5, id_rs_b=5 use_b=1 -> stall=1 one cycle; ex_rd=0 variant -> stall=0.
//  3 mul r4 issued; next id reads r4 -> stall until cycle after md_commit; md_wb_rd=4.
//  4 MD_DEPTH=2: issue mul r6, div r7, third mul -> mdfull stall; md_done pops in order rd 6 then 7.
//  5 md_done while alu_wb_valid=1 -> md_commit=0, stall=1 (wbhold); alu_wb_valid=0 -> commit, data=md_result.
//  6 md_done with empty FIFO -> md_err=1 sticky; reset low mid-op -> pend=0, buf_valid=0, md_ready=1.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard unit: forwarding select encodings, opcode values, counter helper.
package hazard_pkg;

    localparam int FWD_RF = 0;

    localparam logic [4:0] OP_ALU  = 5'd0;
    localparam logic [4:0] OP_SW   = 5'd7;
    localparam logic [4:0] OP_LW   = 5'd8;
    localparam logic [4:0] ALU_MUL = 5'd6;
    localparam logic [4:0] ALU_DIV = 5'd7;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard bus: instruction fields and multdiv handshake in, stall/forward/commit out.
interface hazard_scoreboard_if #(
    parameter int AW   = 5,
    parameter int NFWD = 2,
    parameter int DW   = 32,
    parameter int SW   = $clog2(NFWD + 1)
);
    logic              id_valid;
    logic [AW-1:0]     id_rs_a;
    logic              id_use_a;
    logic [AW-1:0]     id_rs_b;
    logic              id_use_b;
    logic [AW-1:0]     id_rd;
    logic              id_wr;
    logic              id_is_md;
    logic              ex_is_load;
    logic [AW-1:0]     ex_rd;
    logic [NFWD-1:0]   fwd_wr;
    logic [NFWD*AW-1:0] fwd_rd;
    logic              alu_wb_valid;
    logic              md_done;
    logic [DW-1:0]     md_result;
    logic              md_ready;
    logic              md_issue;
    logic              stall;
    logic [SW-1:0]     fwd_sel_a;
    logic [SW-1:0]     fwd_sel_b;
    logic              md_commit;
    logic [AW-1:0]     md_wb_rd;
    logic [DW-1:0]     md_wb_data;
    logic              md_err;
    logic [31:0]       perf_raw_cnt;
    logic [31:0]       perf_lu_cnt;
    logic [31:0]       perf_wb_cnt;

    modport master (
        output id_valid, id_rs_a, id_use_a, id_rs_b, id_use_b, id_rd, id_wr, id_is_md,
               ex_is_load, ex_rd, fwd_wr, fwd_rd, alu_wb_valid, md_done, md_result,
        input  md_ready, md_issue, stall, fwd_sel_a, fwd_sel_b, md_commit, md_wb_rd,
               md_wb_data, md_err, perf_raw_cnt, perf_lu_cnt, perf_wb_cnt
    );

    modport slave (
        input  id_valid, id_rs_a, id_use_a, id_rs_b, id_use_b, id_rd, id_wr, id_is_md,
               ex_is_load, ex_rd, fwd_wr, fwd_rd, alu_wb_valid, md_done, md_result,
        output md_ready, md_issue, stall, fwd_sel_a, fwd_sel_b, md_commit, md_wb_rd,
               md_wb_data, md_err, perf_raw_cnt, perf_lu_cnt, perf_wb_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_md_tag_fifo.sv
// In-order FIFO of destination tags for outstanding multdiv operations.
module md_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [AW-1:0] data_i,
    output logic [AW-1:0] head_o,
    output logic          empty_o,
    output logic          full_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wrap_inc(wr_q);
            if (pop_i)  rd_q <= wrap_inc(rd_q);
            if (push_i && !pop_i)      cnt_q <= cnt_q + CW'(1);
            else if (pop_i && !push_i) cnt_q <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit: multdiv scoreboard, RAW/WAW/load-use stalls, forwarding select, writeback arbitration.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int NFWD     = 2,
    parameter int MD_DEPTH = 2,
    parameter int DW       = 32
) (
    input  logic               clock,
    input  logic               reset,
    hazard_scoreboard_if.slave bus
);
    localparam int SW = $clog2(NFWD + 1);

    logic [NREG-1:0] pend_q, pend_d;
    logic            buf_valid_q, buf_valid_d;
    logic [AW-1:0]   buf_rd_q;
    logic [DW-1:0]   buf_data_q;
    logic            md_err_q;
    logic            fifo_empty, fifo_full;
    logic [AW-1:0]   fifo_head;
    logic            a_live, b_live, raw, waw, lu, mdfull, wbhold;
    logic            stall, md_issue, md_commit, md_ready, accept;

    // Youngest matching stage wins; register 0 is never forwarded.
    function automatic logic [SW-1:0] fwd_pick(input logic [AW-1:0] src,
                                               input logic [NFWD-1:0] wr,
                                               input logic [NFWD*AW-1:0] rd);
        logic [SW-1:0] sel;
        sel = SW'(FWD_RF);
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (wr[k] && rd[k*AW +: AW] == src && src != '0) sel = SW'(k + 1);
        end
        return sel;
    endfunction

    assign a_live = bus.id_use_a && (bus.id_rs_a != '0);
    assign b_live = bus.id_use_b && (bus.id_rs_b != '0);
    assign raw    = (a_live && pend_q[bus.id_rs_a]) || (b_live && pend_q[bus.id_rs_b]);
    assign waw    = bus.id_wr && (bus.id_rd != '0) && pend_q[bus.id_rd];
    assign lu     = bus.ex_is_load && (bus.ex_rd != '0) &&
                    ((a_live && bus.id_rs_a == bus.ex_rd) || (b_live && bus.id_rs_b == bus.ex_rd));
    assign mdfull = bus.id_is_md && fifo_full;
    assign wbhold = buf_valid_q && bus.alu_wb_valid;

    assign stall     = bus.id_valid && (raw || waw || lu || mdfull || wbhold);
    assign md_issue  = bus.id_valid && bus.id_is_md && !stall;
    assign md_commit = buf_valid_q && !bus.alu_wb_valid;
    assign md_ready  = !buf_valid_q || md_commit;
    assign accept    = bus.md_done && md_ready && !fifo_empty;

    md_tag_fifo #(.DEPTH(MD_DEPTH), .AW(AW)) u_tag_fifo (
        .clock  (clock),
        .reset  (reset),
        .push_i (md_issue),
        .pop_i  (accept),
        .data_i (bus.id_rd),
        .head_o (fifo_head),
        .empty_o(fifo_empty),
        .full_o (fifo_full)
    );

    // A commit and a new issue to the same rd in one cycle leave it pending.
    always_comb begin
        pend_d = pend_q;
        if (md_commit) pend_d[buf_rd_q] = 1'b0;
        if (md_issue && bus.id_rd != '0) pend_d[bus.id_rd] = 1'b1;
        pend_d[0] = 1'b0;
        buf_valid_d = buf_valid_q;
        if (accept)         buf_valid_d = 1'b1;
        else if (md_commit) buf_valid_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_q      <= '0;
            buf_valid_q <= 1'b0;
            md_err_q    <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            buf_valid_q <= buf_valid_d;
            if (bus.md_done && fifo_empty) md_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            buf_rd_q   <= fifo_head;
            buf_data_q <= bus.md_result;
        end
    end

    assign bus.stall      = stall;
    assign bus.md_issue   = md_issue;
    assign bus.md_commit  = md_commit;
    assign bus.md_ready   = md_ready;
    assign bus.md_err     = md_err_q;
    assign bus.md_wb_rd   = md_commit ? buf_rd_q : '0;
    assign bus.md_wb_data = md_commit ? buf_data_q : '0;
    assign bus.fwd_sel_a  = fwd_pick(bus.id_rs_a, bus.fwd_wr, bus.fwd_rd);
    assign bus.fwd_sel_b  = fwd_pick(bus.id_rs_b, bus.fwd_wr, bus.fwd_rd);

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_raw_q, perf_lu_q, perf_wb_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_raw_q <= '0;
            perf_lu_q  <= '0;
            perf_wb_q  <= '0;
        end else if (stall) begin
            if (raw || waw)        perf_raw_q <= sat_inc32(perf_raw_q);
            if (lu)                perf_lu_q  <= sat_inc32(perf_lu_q);
            if (mdfull || wbhold)  perf_wb_q  <= sat_inc32(perf_wb_q);
        end
    end

    assign bus.perf_raw_cnt = perf_raw_q;
    assign bus.perf_lu_cnt  = perf_lu_q;
    assign bus.perf_wb_cnt  = perf_wb_q;
`else
    assign bus.perf_raw_cnt = '0;
    assign bus.perf_lu_cnt  = '0;
    assign bus.perf_wb_cnt  = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: combinational vector table plus multdiv sequences with a commit scoreboard.
module tb_hazard_scoreboard;
    localparam int AW   = 5;
    localparam int NFWD = 2;
    localparam int DW   = 32;
    localparam int SW   = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    hazard_scoreboard_if #(.AW(AW), .NFWD(NFWD), .DW(DW)) bus();
    hazard_scoreboard dut (.clock(clock), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic           v;
        logic [1:0]     fwr;
        logic [AW-1:0]  r0, r1, rs_a;
        logic           ua;
        logic [AW-1:0]  rs_b;
        logic           ub;
        logic           ld;
        logic [AW-1:0]  exrd;
        logic           st;
        logic [SW-1:0]  sa, sb;
    } vec_t;

    function automatic vec_t mk(int v, int fwr, int r0, int r1, int rs_a, int ua, int rs_b, int ub,
                                int ld, int exrd, int st, int sa, int sb);
        vec_t t;
        t.v = 1'(v); t.fwr = 2'(fwr); t.r0 = AW'(r0); t.r1 = AW'(r1);
        t.rs_a = AW'(rs_a); t.ua = 1'(ua); t.rs_b = AW'(rs_b); t.ub = 1'(ub);
        t.ld = 1'(ld); t.exrd = AW'(exrd); t.st = 1'(st); t.sa = SW'(sa); t.sb = SW'(sb);
        return t;
    endfunction

    typedef struct { logic [AW-1:0] rd; logic [DW-1:0] data; } res_t;
    res_t          exp_q[$];
    logic [AW-1:0] tag_q[$];
    res_t          m_r;
    logic          m_commit, m_ready;

    // Scoreboard: results queued on accept, popped and compared on commit.
    always @(negedge clock) begin
        #2;
        if (!reset) begin
            exp_q.delete();
            tag_q.delete();
        end else begin
            m_commit = (exp_q.size() != 0) && !bus.alu_wb_valid;
            m_ready  = (exp_q.size() == 0) || m_commit;
            chk("md_commit", 32'(bus.md_commit), 32'(m_commit));
            chk("md_ready", 32'(bus.md_ready), 32'(m_ready));
            if (m_commit) begin
                m_r = exp_q.pop_front();
                chk("commit_rd", 32'(bus.md_wb_rd), 32'(m_r.rd));
                chk("commit_data", 32'(bus.md_wb_data), 32'(m_r.data));
            end
            if (bus.md_done && m_ready && tag_q.size() != 0) begin
                m_r.rd   = tag_q.pop_front();
                m_r.data = bus.md_result;
                exp_q.push_back(m_r);
            end
            if (bus.md_issue) tag_q.push_back(bus.id_rd);
        end
    end

    task automatic idle();
        bus.id_valid = 1'b0; bus.id_rs_a = '0; bus.id_use_a = 1'b0; bus.id_rs_b = '0;
        bus.id_use_b = 1'b0; bus.id_rd = '0; bus.id_wr = 1'b0; bus.id_is_md = 1'b0;
        bus.ex_is_load = 1'b0; bus.ex_rd = '0; bus.fwd_wr = '0; bus.fwd_rd = '0;
        bus.alu_wb_valid = 1'b0; bus.md_done = 1'b0; bus.md_result = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic issue_md(input int rd);
        idle();
        bus.id_valid = 1'b1; bus.id_is_md = 1'b1; bus.id_wr = 1'b1; bus.id_rd = AW'(rd);
    endtask

    task automatic read_a(input int rs);
        idle();
        bus.id_valid = 1'b1; bus.id_use_a = 1'b1; bus.id_rs_a = AW'(rs);
    endtask

    vec_t vt[11];

    initial begin
        idle();
        repeat (2) @(negedge clock);
        #1;
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_md_ready", 32'(bus.md_ready), 32'd1);
        chk("rst_md_err", 32'(bus.md_err), 32'd0);
        chk("rst_md_commit", 32'(bus.md_commit), 32'd0);
        chk("rst_md_issue", 32'(bus.md_issue), 32'd0);
        chk("rst_perf_raw", bus.perf_raw_cnt, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        vt[0]  = mk(1, 3, 3, 3, 3, 1, 0, 0, 0, 0, 0, 1, 0);
        vt[1]  = mk(1, 2, 0, 3, 3, 1, 0, 0, 0, 0, 0, 2, 0);
        vt[2]  = mk(1, 3, 4, 3, 3, 1, 4, 1, 0, 0, 0, 2, 1);
        vt[3]  = mk(1, 3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        vt[4]  = mk(1, 0, 3, 3, 3, 1, 3, 1, 0, 0, 0, 0, 0);
        vt[5]  = mk(1, 0, 0, 0, 1, 1, 5, 1, 1, 5, 1, 0, 0);
        vt[6]  = mk(1, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0);
        vt[7]  = mk(1, 0, 0, 0, 5, 1, 2, 1, 1, 5, 1, 0, 0);
        vt[8]  = mk(1, 0, 0, 0, 1, 1, 5, 0, 1, 5, 0, 0, 0);
        vt[9]  = mk(0, 1, 5, 0, 5, 1, 0, 0, 1, 5, 0, 1, 0);
        vt[10] = mk(1, 1, 2, 0, 2, 1, 2, 1, 1, 2, 1, 1, 1);

        for (int i = 0; i < 11; i++) begin
            idle();
            bus.id_valid = vt[i].v; bus.fwd_wr = vt[i].fwr; bus.fwd_rd = {vt[i].r1, vt[i].r0};
            bus.id_rs_a = vt[i].rs_a; bus.id_use_a = vt[i].ua;
            bus.id_rs_b = vt[i].rs_b; bus.id_use_b = vt[i].ub;
            bus.ex_is_load = vt[i].ld; bus.ex_rd = vt[i].exrd;
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(bus.stall), 32'(vt[i].st));
            chk($sformatf("vec%0d_sel_a", i), 32'(bus.fwd_sel_a), 32'(vt[i].sa));
            chk($sformatf("vec%0d_sel_b", i), 32'(bus.fwd_sel_b), 32'(vt[i].sb));
            tick();
        end

        // mul r4 then a dependent read: stalls through the commit cycle
        issue_md(4); #1;
        chk("s3_issue", 32'(bus.md_issue), 32'd1);
        chk("s3_issue_stall", 32'(bus.stall), 32'd0);
        tick();
        read_a(4); #1;
        chk("s3_raw_stall0", 32'(bus.stall), 32'd1);
        chk("s3_no_issue", 32'(bus.md_issue), 32'd0);
        tick(); #1;
        chk("s3_raw_stall1", 32'(bus.stall), 32'd1);
        tick();
        bus.md_done = 1'b1; bus.md_result = 32'hABCD0004; #1;
        chk("s3_raw_stall2", 32'(bus.stall), 32'd1);
        tick();
        bus.md_done = 1'b0; #1;
        chk("s3_commit", 32'(bus.md_commit), 32'd1);
        chk("s3_wb_rd", 32'(bus.md_wb_rd), 32'd4);
        chk("s3_commit_stall", 32'(bus.stall), 32'd1);
        tick(); #1;
        chk("s3_released", 32'(bus.stall), 32'd0);
        tick();

        // two outstanding ops fill the tag FIFO; results retire in issue order
        issue_md(6); #1;
        chk("s4_issue6", 32'(bus.md_issue), 32'd1);
        tick();
        issue_md(7); #1;
        chk("s4_issue7", 32'(bus.md_issue), 32'd1);
        tick();
        issue_md(8); #1;
        chk("s4_full_stall", 32'(bus.stall), 32'd1);
        chk("s4_full_noissue", 32'(bus.md_issue), 32'd0);
        tick();
        bus.md_done = 1'b1; bus.md_result = 32'h0000_0060; #1;
        chk("s4_full_stall2", 32'(bus.stall), 32'd1);
        tick();
        bus.md_result = 32'h0000_0070; #1;
        chk("s4_commit6", 32'(bus.md_wb_rd), 32'd6);
        chk("s4_issue8", 32'(bus.md_issue), 32'd1);
        chk("s4_unstall", 32'(bus.stall), 32'd0);
        tick();
        idle(); #1;
        chk("s4_commit7", 32'(bus.md_wb_rd), 32'd7);
        tick();
        bus.md_done = 1'b1; bus.md_result = 32'h0000_0080;
        tick();
        bus.md_done = 1'b0; #1;
        chk("s4_commit8", 32'(bus.md_wb_rd), 32'd8);
        tick();

        // ALU writeback blocks the commit and holds decode
        issue_md(9);
        tick();
        idle(); bus.md_done = 1'b1; bus.md_result = 32'h0000_0099;
        tick();
        read_a(1); bus.alu_wb_valid = 1'b1; #1;
        chk("s5_blocked", 32'(bus.md_commit), 32'd0);
        chk("s5_wbhold", 32'(bus.stall), 32'd1);
        tick();
        bus.alu_wb_valid = 1'b0; #1;
        chk("s5_commit", 32'(bus.md_commit), 32'd1);
        chk("s5_data", bus.md_wb_data, 32'h0000_0099);
        chk("s5_nostall", 32'(bus.stall), 32'd0);
        tick();

        // done with no tag outstanding is an error that sticks
        idle(); bus.md_done = 1'b1; bus.md_result = 32'h55; #1;
        chk("s6_err_pre", 32'(bus.md_err), 32'd0);
        tick();
        bus.md_done = 1'b0; #1;
        chk("s6_err_set", 32'(bus.md_err), 32'd1);
        tick(); tick(); #1;
        chk("s6_err_sticky", 32'(bus.md_err), 32'd1);

        // reset with a buffered result and a pending register
        issue_md(10);
        tick();
        idle(); bus.md_done = 1'b1; bus.md_result = 32'hAA;
        tick();
        read_a(10); bus.alu_wb_valid = 1'b1; #1;
        chk("s6_pre_rst_stall", 32'(bus.stall), 32'd1);
        reset = 1'b0; #1;
        chk("s6_rst_ready", 32'(bus.md_ready), 32'd1);
        chk("s6_rst_commit", 32'(bus.md_commit), 32'd0);
        chk("s6_rst_stall", 32'(bus.stall), 32'd0);
        chk("s6_rst_err", 32'(bus.md_err), 32'd0);
        tick();
        reset = 1'b1; bus.alu_wb_valid = 1'b0; #1;
        chk("s6_post_pend", 32'(bus.stall), 32'd0);
        chk("s6_post_commit", 32'(bus.md_commit), 32'd0);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
